// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        LOAD_M = 3'b001,
        LOAD_Q = 3'b010,
        CHECK  = 3'b011,
        ADD    = 3'b100,
        SUB    = 3'b101,
        SHIFT  = 3'b110,
        DONE   = 3'b111
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // {Q[0], Q[-1]} pairs that need an ALU step before the shift.
    localparam logic [1:0] PAIR_SUB = 2'b10;
    localparam logic [1:0] PAIR_ADD = 2'b01;

endpackage

// File: rtl/booth_iter_cnt.sv
// Loadable down-counter tracking the remaining Booth iterations.
module booth_iter_cnt #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Decrement is saturated at zero so a stray dec can never wrap.
    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = CNT_W'(WIDTH);
        end else if (dec && (count_reg != '0)) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign last  = (count_reg == CNT_W'(1));

endmodule

// File: rtl/booth_ctrl.sv
// Control FSM for a radix-2 Booth signed multiplier datapath.
// Optional start-while-busy error flag: define BOOTH_CTRL_START_ERR_EN.
module booth_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic q0,
    input  logic qm1,
    output logic ldm,
    output logic ldq,
    output logic clra,
    output logic clrqm1,
    output logic lda,
    output logic addsub,
    output logic shift,
    output logic busy,
`ifdef BOOTH_CTRL_START_ERR_EN
    output logic start_err,
`endif
    output logic done
);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] iter_count;
    logic             iter_last;
    logic             cnt_load;
    logic             cnt_dec;

    booth_iter_cnt #(
        .WIDTH (WIDTH)
    ) u_iter_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .count (iter_count),
        .last  (iter_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE:    state_next = start ? LOAD_M : IDLE;
            LOAD_M:  state_next = LOAD_Q;
            LOAD_Q:  state_next = CHECK;
            CHECK: begin
                case ({q0, qm1})
                    PAIR_SUB: state_next = SUB;
                    PAIR_ADD: state_next = ADD;
                    default:  state_next = SHIFT;
                endcase
            end
            ADD:     state_next = SHIFT;
            SUB:     state_next = SHIFT;
            // A zero count here means the counter was corrupted; abandon the operation.
            SHIFT: begin
                if (iter_last) begin
                    state_next = DONE;
                end else if (iter_count == '0) begin
                    state_next = IDLE;
                end else begin
                    state_next = CHECK;
                end
            end
            DONE:    state_next = start ? LOAD_M : DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ldm      = 1'b0;
        ldq      = 1'b0;
        clra     = 1'b0;
        clrqm1   = 1'b0;
        lda      = 1'b0;
        addsub   = OP_ADD;
        shift    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_reg)
            LOAD_M: begin
                ldm      = 1'b1;
                busy     = 1'b1;
                cnt_load = 1'b1;
            end
            LOAD_Q: begin
                ldq    = 1'b1;
                clra   = 1'b1;
                clrqm1 = 1'b1;
                busy   = 1'b1;
            end
            CHECK:   busy = 1'b1;
            ADD: begin
                lda    = 1'b1;
                addsub = OP_ADD;
                busy   = 1'b1;
            end
            SUB: begin
                lda    = 1'b1;
                addsub = OP_SUB;
                busy   = 1'b1;
            end
            SHIFT: begin
                shift   = 1'b1;
                busy    = 1'b1;
                cnt_dec = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

`ifdef BOOTH_CTRL_START_ERR_EN
    logic start_err_reg;
    logic start_accept;

    assign start_accept = start && ((state_reg == IDLE) || (state_reg == DONE));

    // Set and clear are mutually exclusive: clear happens only outside busy states.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_err_reg <= 1'b0;
        end else if (start && busy) begin
            start_err_reg <= 1'b1;
        end else if (start_accept) begin
            start_err_reg <= 1'b0;
        end
    end

    assign start_err = start_err_reg;
`endif

endmodule
